mfp_ahb_gpio_ctrl: RTL and testbench
====================================

MFP_AHB_GPIO_CTRL -- requirements
Module: mfp_ahb_gpio_ctrl

Interface
REQ-001 SHALL provide parameter GPIO_WIDTH, default 32: number of GPIO pins, legal range 1..32.
REQ-002 SHALL provide parameter SYNC_STAGES, default 2: input synchroniser depth, legal range 2..4.
REQ-003 SHALL provide parameter OUT_RESET, default 0: DATA_OUT reset value, GPIO_WIDTH bits.
REQ-004 HCLK  input  1  single clock; all state on rising edge.
REQ-005 HRESETn  input  1  reset, asynchronous and active-low.
REQ-006 HADDR input 32, HSIZE input 3, HTRANS input 2, HWRITE input 1, HSEL input 1, HREADY input 1, HWDATA input 32: AHB-Lite slave inputs.
REQ-007 HBURST input 3, HMASTLOCK input 1, HPROT input 4: accepted, ignored.
REQ-008 HRDATA output 32, HREADYOUT output 1, HRESP output 1: AHB-Lite slave outputs.
REQ-009 GPIO_In  input  GPIO_WIDTH  asynchronous pin inputs.
REQ-010 GPIO_Out  output  GPIO_WIDTH  registered DATA_OUT.
REQ-011 GPIO_OE  output  GPIO_WIDTH  registered DIR (1 = drive pin).
REQ-012 GPIO_IRQ  output  1  registered interrupt, OR of IRQ_STATUS.

Function
REQ-013 Register map, word index HADDR[5:2]: 0 DATA_IN (RO), 1 DATA_OUT (RW), 2 DIR (RW), 3 SET (WO), 4 CLR (WO), 5 RISE_EN (RW), 6 FALL_EN (RW), 7 IRQ_STATUS (R/W1C); indices 8..15 unmapped.
REQ-014 Transfer accepted when HSEL & HREADY & HTRANS[1]; address, HWRITE, byte-lane mask latched in address phase.
REQ-015 Byte-lane mask from HSIZE/HADDR[1:0], little-endian: byte, halfword, word; only enabled lanes of writable registers updated.
REQ-016 Writes: zero wait states; register updated on the clock edge ending the data phase using HWDATA.
REQ-017 Reads: exactly one wait state; HREADYOUT low for first data-phase cycle, HRDATA registered and valid in the cycle HREADYOUT is high.
REQ-018 A read whose address phase coincides with a preceding write's data phase SHALL return the post-write value.
REQ-019 HREADYOUT high whenever no read is pending; HRESP constant 0.
REQ-020 Bits at and above GPIO_WIDTH read 0 and ignore writes.
REQ-021 SET write: DATA_OUT |= masked wdata; CLR write: DATA_OUT &= ~masked wdata; both read 0.
REQ-022 DATA_IN = GPIO_In after SYNC_STAGES flops, independent of DIR.
REQ-023 Edge detect on synchronised input vs one-cycle-delayed copy; rising edge sets STATUS bit if RISE_EN bit set, falling edge if FALL_EN bit set.
REQ-024 IRQ_STATUS write: 1 clears bit, 0 no effect; edge event and W1C on same bit same cycle -> bit remains set.
REQ-025 GPIO_IRQ asserted the cycle after any STATUS bit is 1; deasserted the cycle after all are 0.
REQ-026 Unmapped reads return 0; unmapped writes ignored; HTRANS IDLE/BUSY or HSEL low -> no access, HREADYOUT high.
REQ-027 Clearing RISE_EN/FALL_EN SHALL NOT clear already-set STATUS bits.

Reset
REQ-028 On HRESETn low, immediately: DATA_OUT=OUT_RESET, DIR=0, RISE_EN=0, FALL_EN=0, IRQ_STATUS=0, synchroniser and delay flops=0, HRDATA=0, HREADYOUT=1, GPIO_IRQ=0, pending access discarded.
REQ-029 Synchroniser flops at 0 after reset; a pin high at reset release SHALL produce a rising-edge event if RISE_EN set before propagation completes.
REQ-030 Reset asserted mid-read SHALL abort it; first transfer after release behaves as from idle.

Verification
REQ-031 Word write 0xA5 to DATA_OUT, then DIR=0xFF, read back -> GPIO_Out[7:0]=0xA5, GPIO_OE[7:0]=0xFF, read 0xA5 with one wait state.
REQ-032 DATA_OUT=0x0F; SET 0xF0; CLR 0x03 -> DATA_OUT=0xFC; SET/CLR reads return 0.
REQ-033 Byte write 0x5A to HADDR offset 0x05 (DATA_OUT byte 1) with DATA_OUT=0 -> DATA_OUT=0x5A00, other bytes unchanged.
REQ-034 RISE_EN[3]=1, pulse GPIO_In[3] 0->1 -> STATUS=0x8 after SYNC_STAGES+1 cycles, GPIO_IRQ one cycle later; write 0x8 to STATUS -> IRQ drops next cycle.
REQ-035 Write to DIR immediately followed by read of DIR -> read returns new value; W1C and new edge same cycle on bit 0 -> bit 0 stays 1.
REQ-036 Assert HRESETn low during read wait state -> HREADYOUT=1, all registers reset values, next read of DIR returns 0.

Source files
------------

// File: rtl/mfp_ahb_gpio_ctrl_if.sv
// AHB-Lite slave-side bus bundle for the GPIO controller.
// The master drives the request and write-data signals; the slave drives the response signals.
interface mfp_ahb_gpio_ctrl_if;
    logic [31:0] HADDR;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HSEL;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HADDR, HSIZE, HTRANS, HWRITE, HSEL, HREADY, HWDATA, HBURST, HMASTLOCK, HPROT,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HADDR, HSIZE, HTRANS, HWRITE, HSEL, HREADY, HWDATA, HBURST, HMASTLOCK, HPROT,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/mfp_ahb_gpio_ctrl.sv
// AHB-Lite GPIO controller: output/direction registers, set/clear aliases, synchronised inputs
// and edge-triggered interrupt status with write-one-to-clear.
module mfp_ahb_gpio_ctrl #(
    parameter int unsigned            GPIO_WIDTH  = 32,
    parameter int unsigned            SYNC_STAGES = 2,
    parameter logic [GPIO_WIDTH-1:0]  OUT_RESET   = '0
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    mfp_ahb_gpio_ctrl_if.slave        ahb,
    input  logic [GPIO_WIDTH-1:0]     GPIO_In,
    output logic [GPIO_WIDTH-1:0]     GPIO_Out,
    output logic [GPIO_WIDTH-1:0]     GPIO_OE,
    output logic                      GPIO_IRQ
);
    localparam logic [3:0] RegDataIn  = 4'd0;
    localparam logic [3:0] RegDataOut = 4'd1;
    localparam logic [3:0] RegDir     = 4'd2;
    localparam logic [3:0] RegSet     = 4'd3;
    localparam logic [3:0] RegClr     = 4'd4;
    localparam logic [3:0] RegRiseEn  = 4'd5;
    localparam logic [3:0] RegFallEn  = 4'd6;
    localparam logic [3:0] RegIrqStat = 4'd7;

    logic                  accept;
    logic [3:0]            lane_mask;
    logic                  wr_pend_q;
    logic [3:0]            wr_idx_q;
    logic [3:0]            wr_lanes_q;
    logic                  rd_wait_q;
    logic [3:0]            rd_idx_q;
    logic [31:0]           hrdata_q;
    logic [31:0]           rd_val;
    logic [31:0]           lane_bits;
    logic [GPIO_WIDTH-1:0] wmask;
    logic [GPIO_WIDTH-1:0] wdata;
    logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [GPIO_WIDTH-1:0] sync_out;
    logic [GPIO_WIDTH-1:0] dly_q;
    logic [GPIO_WIDTH-1:0] edge_evt;
    logic [GPIO_WIDTH-1:0] w1c;
    logic [GPIO_WIDTH-1:0] data_out_q, data_out_d;
    logic [GPIO_WIDTH-1:0] dir_q, dir_d;
    logic [GPIO_WIDTH-1:0] rise_en_q, rise_en_d;
    logic [GPIO_WIDTH-1:0] fall_en_q, fall_en_d;
    logic [GPIO_WIDTH-1:0] status_q, status_d;
    logic                  irq_q;
    logic                  unused_ahb;

    assign accept = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];

    always_comb begin
        lane_mask = 4'b0000;
        case (ahb.HSIZE)
            3'd0:    lane_mask = 4'b0001 << ahb.HADDR[1:0];
            3'd1:    lane_mask = ahb.HADDR[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    end

    assign lane_bits = {{8{wr_lanes_q[3]}}, {8{wr_lanes_q[2]}},
                        {8{wr_lanes_q[1]}}, {8{wr_lanes_q[0]}}};
    assign wmask     = lane_bits[GPIO_WIDTH-1:0];
    assign wdata     = ahb.HWDATA[GPIO_WIDTH-1:0] & wmask;

    assign sync_out  = sync_q[SYNC_STAGES-1];
    assign edge_evt  = (sync_out & ~dly_q & rise_en_q) | (~sync_out & dly_q & fall_en_q);

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        w1c        = '0;
        if (wr_pend_q) begin
            case (wr_idx_q)
                RegDataOut: data_out_d = (data_out_q & ~wmask) | wdata;
                RegDir:     dir_d      = (dir_q & ~wmask) | wdata;
                RegSet:     data_out_d = data_out_q | wdata;
                RegClr:     data_out_d = data_out_q & ~wdata;
                RegRiseEn:  rise_en_d  = (rise_en_q & ~wmask) | wdata;
                RegFallEn:  fall_en_d  = (fall_en_q & ~wmask) | wdata;
                RegIrqStat: w1c        = wdata;
                default:    ;
            endcase
        end
        // A new edge wins over a simultaneous clear of the same bit.
        status_d = (status_q & ~w1c) | edge_evt;
    end

    // Sampled in the read wait state, after any preceding write has already landed.
    always_comb begin
        rd_val = '0;
        case (rd_idx_q)
            RegDataIn:  rd_val[GPIO_WIDTH-1:0] = sync_out;
            RegDataOut: rd_val[GPIO_WIDTH-1:0] = data_out_q;
            RegDir:     rd_val[GPIO_WIDTH-1:0] = dir_q;
            RegRiseEn:  rd_val[GPIO_WIDTH-1:0] = rise_en_q;
            RegFallEn:  rd_val[GPIO_WIDTH-1:0] = fall_en_q;
            RegIrqStat: rd_val[GPIO_WIDTH-1:0] = status_q;
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_pend_q  <= 1'b0;
            wr_idx_q   <= '0;
            wr_lanes_q <= '0;
            rd_wait_q  <= 1'b0;
            rd_idx_q   <= '0;
            hrdata_q   <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            dly_q      <= '0;
            data_out_q <= OUT_RESET;
            dir_q      <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            status_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            wr_pend_q <= accept & ahb.HWRITE;
            rd_wait_q <= accept & ~ahb.HWRITE;
            if (accept) begin
                wr_idx_q   <= ahb.HADDR[5:2];
                wr_lanes_q <= lane_mask;
                rd_idx_q   <= ahb.HADDR[5:2];
            end
            if (rd_wait_q) hrdata_q <= rd_val;
            sync_q[0] <= GPIO_In;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            dly_q      <= sync_out;
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            status_q   <= status_d;
            irq_q      <= |status_q;
        end
    end

    assign ahb.HRDATA    = hrdata_q;
    assign ahb.HREADYOUT = ~rd_wait_q;
    assign ahb.HRESP     = 1'b0;
    assign GPIO_Out      = data_out_q;
    assign GPIO_OE       = dir_q;
    assign GPIO_IRQ      = irq_q;

    assign unused_ahb = ^{ahb.HBURST, ahb.HMASTLOCK, ahb.HPROT, ahb.HADDR[31:6], ahb.HTRANS[0],
                          ahb.HWDATA, lane_bits};
endmodule

// File: tb/tb_mfp_ahb_gpio_ctrl.sv
// Directed bench for the AHB GPIO controller: a table of register accesses with expected
// read data and pin outputs, then hand-written sequences for edges, interrupts and reset.
module tb_mfp_ahb_gpio_ctrl;
    localparam logic [23:0] OutRst = 24'hC00001;
    localparam logic [3:0] IDin = 4'd0, IDout = 4'd1, IDir = 4'd2, ISet = 4'd3, IClr = 4'd4;
    localparam logic [3:0] IRise = 4'd5, IFall = 4'd6, IStat = 4'd7;

    typedef struct {
        bit          wr;
        logic [3:0]  idx;
        logic [2:0]  size;
        logic [1:0]  off;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic [23:0] exp_out;
        logic [23:0] exp_oe;
    } vec_t;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [23:0] gpio_in = 24'h123456;
    logic [23:0] gpio_out;
    logic [23:0] gpio_oe;
    logic        gpio_irq;
    int          errors = 0;
    int          checks = 0;
    vec_t        vecs[$];

    mfp_ahb_gpio_ctrl_if bus ();
    assign bus.HREADY = bus.HREADYOUT;

    mfp_ahb_gpio_ctrl #(
        .GPIO_WIDTH  (24),
        .SYNC_STAGES (2),
        .OUT_RESET   (OutRst)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .ahb      (bus),
        .GPIO_In  (gpio_in),
        .GPIO_Out (gpio_out),
        .GPIO_OE  (gpio_oe),
        .GPIO_IRQ (gpio_irq)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
    endtask

    task automatic drive_addr(input logic [3:0] idx, input logic [2:0] size,
                              input logic [1:0] off, input bit wr);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = wr;
        bus.HSIZE  = size;
        bus.HADDR  = {26'h1000000, idx, off};
    endtask

    // All bus tasks start and return 1 time unit after a rising edge.
    task automatic ahb_write(input logic [3:0] idx, input logic [2:0] size,
                             input logic [1:0] off, input logic [31:0] data);
        drive_addr(idx, size, off, 1'b1);
        @(posedge HCLK); #1;
        bus_idle();
        bus.HWDATA = data;
        chk("write zero wait", {31'd0, bus.HREADYOUT}, 32'd1);
        @(posedge HCLK); #1;
    endtask

    task automatic wait_data(output logic [31:0] rdata, output int waits);
        waits = 0;
        while (bus.HREADYOUT !== 1'b1 && waits < 8) begin
            waits++;
            @(posedge HCLK); #1;
        end
        rdata = bus.HRDATA;
    endtask

    task automatic ahb_read(input logic [3:0] idx, output logic [31:0] rdata, output int waits);
        drive_addr(idx, 3'd2, 2'd0, 1'b0);
        @(posedge HCLK); #1;
        bus_idle();
        wait_data(rdata, waits);
    endtask

    task automatic wr_then_rd(input logic [3:0] idx, input logic [31:0] data,
                              output logic [31:0] rdata, output int waits);
        drive_addr(idx, 3'd2, 2'd0, 1'b1);
        @(posedge HCLK); #1;
        drive_addr(idx, 3'd2, 2'd0, 1'b0);
        bus.HWDATA = data;
        @(posedge HCLK); #1;
        bus_idle();
        wait_data(rdata, waits);
    endtask

    function automatic vec_t mk(bit wr, logic [3:0] idx, logic [2:0] size, logic [1:0] off,
                                logic [31:0] data, logic [31:0] exp_rd,
                                logic [23:0] exp_out, logic [23:0] exp_oe);
        vec_t v;
        v.wr = wr; v.idx = idx; v.size = size; v.off = off; v.data = data;
        v.exp_rd = exp_rd; v.exp_out = exp_out; v.exp_oe = exp_oe;
        return v;
    endfunction

    task automatic rd_chk(input string name, input logic [3:0] idx, input logic [31:0] exp);
        logic [31:0] rd;
        int          w;
        ahb_read(idx, rd, w);
        chk({name, " data"}, rd, exp);
        chk({name, " waits"}, w, 1);
    endtask

    initial begin
        logic [31:0] rd;
        int          w;
        vec_t        v;

        bus_idle();
        bus.HADDR = '0; bus.HSIZE = 3'd2; bus.HWDATA = '0;
        bus.HBURST = '0; bus.HMASTLOCK = 1'b0; bus.HPROT = 4'h3;

        repeat (3) @(posedge HCLK);
        #1;
        chk("reset hreadyout", {31'd0, bus.HREADYOUT}, 32'd1);
        chk("reset hresp", {31'd0, bus.HRESP}, 32'd0);
        chk("reset hrdata", bus.HRDATA, 32'd0);
        chk("reset gpio_out", {8'd0, gpio_out}, {8'd0, OutRst});
        chk("reset gpio_oe", {8'd0, gpio_oe}, 32'd0);
        chk("reset irq", {31'd0, gpio_irq}, 32'd0);
        HRESETn = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;

        //                 wr idx    size off   data            exp_rd          out         oe
        vecs.push_back(mk(0, IDout, 3'd2, 2'd0, 32'h0,          32'h00C00001, 24'hC00001, 24'h0));
        vecs.push_back(mk(0, IDir,  3'd2, 2'd0, 32'h0,          32'h0,        24'hC00001, 24'h0));
        vecs.push_back(mk(0, IDin,  3'd2, 2'd0, 32'h0,          32'h00123456, 24'hC00001, 24'h0));
        vecs.push_back(mk(0, IStat, 3'd2, 2'd0, 32'h0,          32'h0,        24'hC00001, 24'h0));
        vecs.push_back(mk(1, IDout, 3'd2, 2'd0, 32'hA5,         32'h0,        24'h0000A5, 24'h0));
        vecs.push_back(mk(1, IDir,  3'd2, 2'd0, 32'hFF,         32'h0,        24'h0000A5, 24'hFF));
        vecs.push_back(mk(0, IDout, 3'd2, 2'd0, 32'h0,          32'hA5,       24'h0000A5, 24'hFF));
        vecs.push_back(mk(0, IDir,  3'd2, 2'd0, 32'h0,          32'hFF,       24'h0000A5, 24'hFF));
        vecs.push_back(mk(1, IDout, 3'd2, 2'd0, 32'h0F,         32'h0,        24'h00000F, 24'hFF));
        vecs.push_back(mk(1, ISet,  3'd2, 2'd0, 32'hF0,         32'h0,        24'h0000FF, 24'hFF));
        vecs.push_back(mk(1, IClr,  3'd2, 2'd0, 32'h03,         32'h0,        24'h0000FC, 24'hFF));
        vecs.push_back(mk(0, ISet,  3'd2, 2'd0, 32'h0,          32'h0,        24'h0000FC, 24'hFF));
        vecs.push_back(mk(0, IClr,  3'd2, 2'd0, 32'h0,          32'h0,        24'h0000FC, 24'hFF));
        vecs.push_back(mk(0, IDout, 3'd2, 2'd0, 32'h0,          32'hFC,       24'h0000FC, 24'hFF));
        vecs.push_back(mk(1, IDout, 3'd2, 2'd0, 32'h0,          32'h0,        24'h000000, 24'hFF));
        vecs.push_back(mk(1, IDout, 3'd0, 2'd1, 32'hFFFF5AFF,   32'h0,        24'h005A00, 24'hFF));
        vecs.push_back(mk(1, IDout, 3'd1, 2'd2, 32'h1234FFFF,   32'h0,        24'h345A00, 24'hFF));
        vecs.push_back(mk(0, IDout, 3'd2, 2'd0, 32'h0,          32'h345A00,   24'h345A00, 24'hFF));
        vecs.push_back(mk(1, IDir,  3'd2, 2'd0, 32'hFFFFFFFF,   32'h0,        24'h345A00, 24'hFFFFFF));
        vecs.push_back(mk(0, IDir,  3'd2, 2'd0, 32'h0,          32'h00FFFFFF, 24'h345A00, 24'hFFFFFF));
        vecs.push_back(mk(1, 4'd9,  3'd2, 2'd0, 32'hFFFFFFFF,   32'h0,        24'h345A00, 24'hFFFFFF));
        vecs.push_back(mk(0, 4'd9,  3'd2, 2'd0, 32'h0,          32'h0,        24'h345A00, 24'hFFFFFF));
        vecs.push_back(mk(0, 4'd15, 3'd2, 2'd0, 32'h0,          32'h0,        24'h345A00, 24'hFFFFFF));
        vecs.push_back(mk(1, IDin,  3'd2, 2'd0, 32'hFFFFFFFF,   32'h0,        24'h345A00, 24'hFFFFFF));
        vecs.push_back(mk(0, IDin,  3'd2, 2'd0, 32'h0,          32'h00123456, 24'h345A00, 24'hFFFFFF));
        vecs.push_back(mk(1, ISet,  3'd0, 2'd2, 32'hFFABFFFF,   32'h0,        24'hBF5A00, 24'hFFFFFF));
        vecs.push_back(mk(1, IClr,  3'd1, 2'd0, 32'hFFFF0F00,   32'h0,        24'hBF5000, 24'hFFFFFF));
        vecs.push_back(mk(0, IDout, 3'd2, 2'd0, 32'h0,          32'hBF5000,   24'hBF5000, 24'hFFFFFF));
        vecs.push_back(mk(1, IDir,  3'd2, 2'd0, 32'h0,          32'h0,        24'hBF5000, 24'h0));
        vecs.push_back(mk(1, IRise, 3'd2, 2'd0, 32'h8,          32'h0,        24'hBF5000, 24'h0));
        vecs.push_back(mk(0, IRise, 3'd2, 2'd0, 32'h0,          32'h8,        24'hBF5000, 24'h0));
        vecs.push_back(mk(1, IFall, 3'd0, 2'd1, 32'h00000400,   32'h0,        24'hBF5000, 24'h0));
        vecs.push_back(mk(0, IFall, 3'd2, 2'd0, 32'h0,          32'h400,      24'hBF5000, 24'h0));
        vecs.push_back(mk(0, IStat, 3'd2, 2'd0, 32'h0,          32'h0,        24'hBF5000, 24'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.wr) begin
                ahb_write(v.idx, v.size, v.off, v.data);
            end else begin
                ahb_read(v.idx, rd, w);
                chk($sformatf("vec%0d rdata", i), rd, v.exp_rd);
                chk($sformatf("vec%0d waits", i), w, 1);
            end
            chk($sformatf("vec%0d gpio_out", i), {8'd0, gpio_out}, {8'd0, v.exp_out});
            chk($sformatf("vec%0d gpio_oe", i), {8'd0, gpio_oe}, {8'd0, v.exp_oe});
        end

        // Rising edge on pin 3: status after 3 edges, irq one edge later, W1C drops irq.
        gpio_in[3] = 1'b1;
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        chk("rise irq edge2", {31'd0, gpio_irq}, 32'd0);
        @(posedge HCLK); #1;
        chk("rise irq edge3", {31'd0, gpio_irq}, 32'd0);
        @(posedge HCLK); #1;
        chk("rise irq edge4", {31'd0, gpio_irq}, 32'd1);
        rd_chk("rise status", IStat, 32'h8);
        ahb_write(IStat, 3'd2, 2'd0, 32'h8);
        chk("w1c irq commit", {31'd0, gpio_irq}, 32'd1);
        @(posedge HCLK); #1;
        chk("w1c irq after", {31'd0, gpio_irq}, 32'd0);
        rd_chk("w1c status", IStat, 32'h0);

        // Write immediately followed by read of the same register.
        wr_then_rd(IDir, 32'h5A5A5A, rd, w);
        chk("raw dir data", rd, 32'h5A5A5A);
        chk("raw dir waits", w, 1);

        // Disabling an edge source keeps its status bit.
        ahb_write(IRise, 3'd2, 2'd0, 32'h9);
        gpio_in[0] = 1'b1;
        repeat (5) @(posedge HCLK);
        #1;
        ahb_write(IRise, 3'd2, 2'd0, 32'h8);
        rd_chk("status kept", IStat, 32'h1);
        ahb_write(IRise, 3'd2, 2'd0, 32'h9);
        gpio_in[0] = 1'b0;
        repeat (5) @(posedge HCLK);
        #1;
        // Rising edge on pin 0 lands on the same edge as the W1C commit.
        gpio_in[0] = 1'b1;
        @(posedge HCLK); #1;
        ahb_write(IStat, 3'd2, 2'd0, 32'h1);
        rd_chk("w1c vs edge", IStat, 32'h1);
        ahb_write(IStat, 3'd2, 2'd0, 32'h1);
        rd_chk("w1c alone", IStat, 32'h0);

        // Falling edge on pin 10.
        gpio_in[10] = 1'b0;
        repeat (5) @(posedge HCLK);
        #1;
        rd_chk("fall status", IStat, 32'h400);
        ahb_write(IStat, 3'd2, 2'd0, 32'h400);
        rd_chk("fall cleared", IStat, 32'h0);

        // BUSY transfer and deselected transfer are not accesses.
        drive_addr(IDout, 3'd2, 2'd0, 1'b1);
        bus.HTRANS = 2'b01;
        @(posedge HCLK); #1;
        bus_idle();
        bus.HWDATA = 32'h0;
        chk("busy hreadyout", {31'd0, bus.HREADYOUT}, 32'd1);
        @(posedge HCLK); #1;
        chk("busy gpio_out", {8'd0, gpio_out}, 32'hBF5000);
        drive_addr(IDout, 3'd2, 2'd0, 1'b0);
        bus.HSEL = 1'b0;
        @(posedge HCLK); #1;
        bus_idle();
        chk("nosel hreadyout", {31'd0, bus.HREADYOUT}, 32'd1);

        // Reset during the read wait state.
        drive_addr(IDir, 3'd2, 2'd0, 1'b0);
        @(posedge HCLK); #1;
        bus_idle();
        chk("pre-reset wait", {31'd0, bus.HREADYOUT}, 32'd0);
        HRESETn = 1'b0;
        #1;
        chk("mid reset hreadyout", {31'd0, bus.HREADYOUT}, 32'd1);
        chk("mid reset gpio_out", {8'd0, gpio_out}, {8'd0, OutRst});
        chk("mid reset gpio_oe", {8'd0, gpio_oe}, 32'd0);
        chk("mid reset hrdata", bus.HRDATA, 32'd0);
        repeat (2) @(posedge HCLK);
        #1;
        // Pin 2 is already high at release; enabling its rising edge quickly catches it.
        HRESETn = 1'b1;
        ahb_write(IRise, 3'd2, 2'd0, 32'h4);
        rd_chk("post reset dir", IDir, 32'h0);
        rd_chk("post reset fall_en", IFall, 32'h0);
        rd_chk("release edge status", IStat, 32'h4);
        chk("release edge irq", {31'd0, gpio_irq}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
